// File: rtl/instr_encoder_loader.sv
// Streams symbolic lw/sw/R-type/beq records, encodes them into RV32I words and
// writes them to consecutive instruction-memory addresses in one load session.
module instr_encoder_loader #(
  parameter int unsigned           ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]     BASE_ADDR = '0,
  parameter int unsigned           DEPTH     = 64,
  localparam int unsigned          CW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_f7b5,
  input  logic [12:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     word_count,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LAST, S_DONE} state_t;
  typedef enum logic [1:0] {K_LW, K_SW, K_R, K_BEQ} kind_t;

  state_t      state, state_nx;
  kind_t       kind;
  logic [CW:0] fill;
  logic        full, accept, imm_bad, beq_odd, rec_err, overflow;
  logic [31:0] enc;

  assign kind = kind_t'(in_kind);

  // A registered-but-not-yet-counted write still occupies a slot.
  assign fill     = {1'b0, word_count} + {{CW{1'b0}}, imem_we};
  assign full     = (fill >= (CW+1)'(DEPTH));
  assign in_ready = (state == S_LOAD) & ~err & ~full;
  assign accept   = in_valid & in_ready;
  assign overflow = (state == S_LOAD) & ~err & full & in_valid;

  assign imm_bad  = ((kind == K_LW) | (kind == K_SW)) & (in_imm[12] != in_imm[11]);
  assign beq_odd  = (kind == K_BEQ) & in_imm[0];
  assign rec_err  = imm_bad | beq_odd;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_comb begin
    enc = '0;
    unique case (kind)
      K_LW:  enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
      K_SW:  enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
      K_R:   enc = {1'b0, in_f7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      K_BEQ: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000, in_imm[4:1],
                    in_imm[11], 7'b1100011};
      default: enc = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_LOAD;
      S_LOAD: begin
        if (accept & in_last)             state_nx = rec_err ? S_DONE : S_LAST;
        else if (err & in_valid & in_last) state_nx = S_DONE;
      end
      S_LAST: state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      imem_we    <= 1'b0;
      imem_wdata <= '0;
      imem_addr  <= BASE_ADDR;
      word_count <= '0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      state   <= state_nx;
      imem_we <= accept & ~rec_err;
      if (accept & ~rec_err) imem_wdata <= enc;
      if (imem_we) begin
        imem_addr  <= imem_addr + ADDR_W'(4);
        word_count <= word_count + CW'(1);
      end
      if ((state == S_IDLE) & start) begin
        imem_addr  <= BASE_ADDR;
        word_count <= '0;
        err        <= 1'b0;
        err_code   <= 2'b00;
      end
      if (accept & rec_err) begin
        err      <= 1'b1;
        err_code <= imm_bad ? 2'b01 : 2'b10;
      end
      if (overflow) begin
        err      <= 1'b1;
        err_code <= 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized and directed load sessions against a behavioural encoder/loader model.
module tb_instr_encoder_loader;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] BASE = 32'h0;

  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [12:0] imm;
  } rec_t;

  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, in_last = 0, in_f7b5 = 0;
  logic in_ready, imem_we, busy, done, err;
  logic [1:0] in_kind = 0, err_code;
  logic [4:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [2:0] in_funct3 = 0;
  logic [12:0] in_imm = 0;
  logic [31:0] imem_addr, imem_wdata;
  logic [CW-1:0] word_count;

  int errors = 0, checks = 0, cyc = 0;
  logic [31:0] wa[$], wd[$];
  int wcyc[$];

  instr_encoder_loader #(.ADDR_W(32), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
    .done(done), .word_count(word_count), .err(err), .err_code(err_code));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (imem_we) begin
    wa.push_back(imem_addr); wd.push_back(imem_wdata); wcyc.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input rec_t r);
    case (r.kind)
      2'd0: return {r.imm[11:0], r.rs1, 3'b010, r.rd, 7'b0000011};
      2'd1: return {r.imm[11:5], r.rs2, r.rs1, 3'b010, r.imm[4:0], 7'b0100011};
      2'd2: return {1'b0, r.f7, 5'b0, r.rs2, r.rs1, r.f3, r.rd, 7'b0110011};
      default: return {r.imm[12], r.imm[10:5], r.rs2, r.rs1, 3'b000, r.imm[4:1], r.imm[11], 7'b1100011};
    endcase
  endfunction

  // 0 = ok, 1 = immediate out of 12-bit range, 2 = odd branch offset
  function automatic int model_err(input rec_t r);
    int s;
    s = int'($signed(r.imm));
    if (r.kind <= 2'd1 && (s < -2048 || s > 2047)) return 1;
    if (r.kind == 2'd3 && (s % 2) != 0) return 2;
    return 0;
  endfunction

  function automatic rec_t mk(input int kind, input int rd, input int rs1, input int rs2,
                              input int f3, input int f7, input int imm);
    rec_t r;
    r.kind = 2'(kind); r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
    r.f3 = 3'(f3); r.f7 = 1'(f7); r.imm = 13'(imm);
    return r;
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    int v;
    r = rec_t'({$urandom, $urandom});
    v = int'($urandom_range(0, 4095)) - 2048;
    if ($urandom_range(0, 11) == 0) begin
      if (r.kind <= 2'd1) r.imm = 13'(($urandom_range(0, 1) == 1) ? 2048 + v + 2048 : -2049 - (v + 2048));
      else if (r.kind == 2'd3) r.imm = 13'(2 * v + 1);
    end else begin
      if (r.kind == 2'd3) r.imm = 13'(2 * v);
      else if (r.kind <= 2'd1) r.imm = 13'(v);
    end
    return r;
  endfunction

  task automatic drive(input rec_t r, input logic last);
    in_valid = 1; in_last = last; in_kind = r.kind; in_rd = r.rd; in_rs1 = r.rs1;
    in_rs2 = r.rs2; in_funct3 = r.f3; in_f7b5 = r.f7; in_imm = r.imm;
  endtask

  task automatic run_session(input rec_t recs[$], input int bubble_pct, input bit b2b);
    logic [31:0] ea[$], ed[$];
    int cnt = 0, code = 0, merr = 0, ended = 0, e, got = 0;
    wa.delete(); wd.delete(); wcyc.delete();
    @(negedge clk);
    start = 1;
    drive(recs[0], 1'b1);           // start wins over a simultaneous record
    @(negedge clk);
    start = 0; in_valid = 0; in_last = 0;
    #1 check("start_clears_err", {err, err_code, word_count}, '0);
    for (int i = 0; i < recs.size() && !ended && !merr; i++) begin
      while (int'($urandom_range(0, 99)) < bubble_pct) begin
        in_valid = 0; @(negedge clk);
      end
      drive(recs[i], i == recs.size() - 1);
      #1;
      if (cnt == DEPTH) begin
        check("ready_full", in_ready, 0);
        @(negedge clk);
        merr = 1; code = 3;
      end else begin
        check("ready", in_ready, 1);
        @(negedge clk);
        e = model_err(recs[i]);
        if (e != 0) begin merr = 1; code = e; end
        else begin
          ea.push_back(BASE + 32'(4 * cnt)); ed.push_back(model_word(recs[i])); cnt++;
        end
        if (i == recs.size() - 1) ended = 1;
      end
    end
    if (!ended) begin
      in_valid = 1; in_last = 1;
      #1 check("ready_after_err", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 0; in_last = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      #1;
      if (done) begin
        got = 1;
        check("word_count", word_count, cnt);
        check("err", err, merr);
        check("err_code", err_code, code);
        check("busy_done", busy, 1);
        @(negedge clk); #1;
        check("done_pulse", {done, busy}, 0);
      end else @(negedge clk);
    end
    check("done_seen", got, 1);
    check("nwrites", wa.size(), ea.size());
    for (int k = 0; k < ea.size() && k < wa.size(); k++) begin
      check("addr", wa[k], ea[k]);
      check("wdata", wd[k], ed[k]);
    end
    if (b2b && wcyc.size() > 1) check("b2b", wcyc[wcyc.size()-1] - wcyc[0], wcyc.size() - 1);
  endtask

  initial begin
    rec_t q[$];
    int n0;
    #12;
    check("rst_outs", {in_ready, imem_we, done, busy, err, word_count, err_code}, '0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_addr", imem_addr, BASE);
    rst_n = 1;

    q = '{mk(0, 5, 2, 0, 0, 0, 8)};
    run_session(q, 0, 0);
    check("ex_lw", wd.size() > 0 ? wd[0] : 32'hx, 32'h00812283);

    q = '{mk(1, 0, 2, 6, 0, 0, 12), mk(2, 7, 5, 6, 0, 0, 0), mk(2, 7, 5, 6, 0, 1, 0),
          mk(3, 0, 5, 6, 0, 0, -4)};
    run_session(q, 0, 1);
    if (wd.size() == 4) begin
      check("ex_sw", wd[0], 32'h00612623);
      check("ex_add", wd[1], 32'h006283B3);
      check("ex_sub", wd[2], 32'h406283B3);
      check("ex_beq", wd[3], 32'hFE628EE3);
      check("ex_addr3", wa[3], 32'hC);
    end else check("ex_count", wd.size(), 4);

    q = '{mk(2, 1, 1, 1, 0, 0, 0), mk(0, 1, 1, 0, 0, 0, 13'h0800), mk(2, 1, 1, 1, 0, 0, 0)};
    run_session(q, 0, 0);
    q = '{mk(3, 0, 1, 2, 0, 0, 3), mk(2, 1, 1, 1, 0, 0, 0)};
    run_session(q, 0, 0);

    q.delete();
    for (int i = 0; i < 9; i++) q.push_back(mk(2, i, i, i, i, 0, 0));
    run_session(q, 0, 1);
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(mk(0, i, 1, 0, 0, 0, 4 * i));
    run_session(q, 0, 1);

    @(negedge clk); start = 1;
    @(negedge clk); start = 0; drive(mk(0, 1, 1, 0, 0, 0, 0), 0);
    @(negedge clk); drive(mk(0, 2, 1, 0, 0, 0, 4), 0);
    #1 n0 = wa.size();
    rst_n = 0;
    #1 check("rst_mid", {imem_we, busy, in_ready}, 0);
    check("rst_mid_addr", imem_addr, BASE);
    @(negedge clk); @(negedge clk); rst_n = 1; in_valid = 0;
    repeat (3) @(negedge clk);
    check("rst_no_write", wa.size(), n0);

    for (int s = 0; s < 20; s++) begin
      q.delete();
      for (int i = 0, n = $urandom_range(1, 10); i < n; i++) q.push_back(rand_rec());
      run_session(q, 30, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
